// File: rtl/seq_priority_encoder_if.sv
// Request/response bundle for seq_priority_encoder.
// The master side is the environment; the slave side is the encoder.
interface seq_priority_encoder_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned OUT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] encoder_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] binary_out;
    logic             out_last;
    logic             zero;
    logic             error;

    modport master (
        output in_valid, mode, encoder_in, out_ready,
        input  in_ready, out_valid, binary_out, out_last, zero, error
    );

    modport slave (
        input  in_valid, mode, encoder_in, out_ready,
        output in_ready, out_valid, binary_out, out_last, zero, error
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// Registered WIDTH-to-index encoder with strict one-hot, LSB, MSB and
// serialising modes, valid/ready on both sides.
module seq_priority_encoder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    seq_priority_encoder_if.slave  bus
);
    localparam int unsigned OUT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SCAN} state_t;

    function automatic logic [OUT_W-1:0] lsb_idx(input logic [WIDTH-1:0] v);
        lsb_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) lsb_idx = OUT_W'(i);
        end
    endfunction

    function automatic logic [OUT_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) msb_idx = OUT_W'(i);
        end
    endfunction

    function automatic logic at_most_one(input logic [WIDTH-1:0] v);
        at_most_one = ((v & (v - WIDTH'(1))) == '0);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;
    logic             r_valid;
    logic [OUT_W-1:0] r_idx;
    logic             r_last;
    logic             r_zero;
    logic             r_err;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_mask;
    logic             w_nxt_valid;
    logic [OUT_W-1:0] w_nxt_idx;
    logic             w_nxt_last;
    logic             w_nxt_zero;
    logic             w_nxt_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_hs;
    logic             w_vec_zero;
    logic             w_vec_single;
    logic [WIDTH-1:0] w_mask_rem;

    // Ready as soon as the slot is empty or its final beat is leaving.
    assign w_in_ready   = enable && (!r_valid || (bus.out_ready && r_last));
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_hs         = r_valid && bus.out_ready;
    assign w_vec_zero   = (bus.encoder_in == '0);
    assign w_vec_single = at_most_one(bus.encoder_in);
    assign w_mask_rem   = r_mask & (r_mask - WIDTH'(1));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mask  = r_mask;
        w_nxt_valid = r_valid;
        w_nxt_idx   = r_idx;
        w_nxt_last  = r_last;
        w_nxt_zero  = r_zero;
        w_nxt_err   = r_err;

        if (w_accept) begin
            w_nxt_state = ST_HOLD;
            w_nxt_mask  = bus.encoder_in;
            w_nxt_valid = 1'b1;
            w_nxt_last  = 1'b1;
            w_nxt_zero  = w_vec_zero;
            w_nxt_err   = 1'b0;
            case (bus.mode)
                2'd0: begin
                    w_nxt_err = !(w_vec_single && !w_vec_zero);
                    w_nxt_idx = w_nxt_err ? '0 : lsb_idx(bus.encoder_in);
                end
                2'd1:    w_nxt_idx = lsb_idx(bus.encoder_in);
                2'd2:    w_nxt_idx = msb_idx(bus.encoder_in);
                default: begin
                    w_nxt_idx = lsb_idx(bus.encoder_in);
                    if (!w_vec_single) begin
                        w_nxt_state = ST_SCAN;
                        w_nxt_last  = 1'b0;
                    end
                end
            endcase
        end else if (w_hs && r_last) begin
            w_nxt_state = ST_IDLE;
            w_nxt_valid = 1'b0;
        end else if (w_hs && (r_state == ST_SCAN)) begin
            // Drop the bit just delivered and present the next lowest.
            w_nxt_mask = w_mask_rem;
            w_nxt_idx  = lsb_idx(w_mask_rem);
            w_nxt_last = at_most_one(w_mask_rem);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mask  <= w_nxt_mask;
            r_valid <= w_nxt_valid;
            r_idx   <= w_nxt_idx;
            r_last  <= w_nxt_last;
            r_zero  <= w_nxt_zero;
            r_err   <= w_nxt_err;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.binary_out = r_idx;
    assign bus.out_last   = r_last;
    assign bus.zero       = r_zero;
    assign bus.error      = r_err;
endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: vector table, directed multi-cycle sequences,
// and random traffic scored against a beat-queue reference model.
module tb_seq_priority_encoder;
    logic clk;
    logic reset;
    logic enable;

    seq_priority_encoder_if #(.WIDTH(16)) bus16 ();
    seq_priority_encoder_if #(.WIDTH(5))  bus5 ();

    seq_priority_encoder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus16)
    );
    seq_priority_encoder #(.WIDTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
        bit zero;
        bit err;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] vec;
        int          idx;
        bit          zero;
        bit          err;
    } vec_t;

    beat_t exp_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    logic  mon_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Expected beats for one accepted job, straight from the mode rules.
    function automatic void model(input logic [1:0] m, input logic [15:0] v);
        int    n;
        int    k;
        beat_t b;
        n = $countones(v);
        b.idx = 0; b.last = 1'b1; b.zero = 1'b0; b.err = 1'b0;
        if (n == 0) begin
            b.zero = 1'b1;
            b.err  = (m == 2'd0);
            exp_q.push_back(b);
            return;
        end
        case (m)
            2'd0: begin
                if (n == 1) begin
                    for (int i = 0; i < 16; i++) if (v[i]) b.idx = i;
                end else begin
                    b.err = 1'b1;
                end
                exp_q.push_back(b);
            end
            2'd1: begin
                for (int i = 15; i >= 0; i--) if (v[i]) b.idx = i;
                exp_q.push_back(b);
            end
            2'd2: begin
                for (int i = 0; i < 16; i++) if (v[i]) b.idx = i;
                exp_q.push_back(b);
            end
            default: begin
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    if (v[i]) begin
                        b.idx  = i;
                        b.last = (k == n - 1);
                        exp_q.push_back(b);
                        k++;
                    end
                end
            end
        endcase
    endfunction

    // Scoreboard on the 16-bit instance; inputs only change just after posedge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            mon_ready = enable && (exp_q.size() == 0 || (bus16.out_ready && exp_q.size() == 1));
            check("mon_in_ready", 32'(bus16.in_ready), 32'(mon_ready));
            if (exp_q.size() == 0) begin
                check("mon_idle_valid", 32'(bus16.out_valid), 32'd0);
            end else begin
                check("mon_valid", 32'(bus16.out_valid), 32'd1);
                check("mon_idx",   32'(bus16.binary_out), 32'(exp_q[0].idx));
                check("mon_last",  32'(bus16.out_last), 32'(exp_q[0].last));
                check("mon_zero",  32'(bus16.zero), 32'(exp_q[0].zero));
                check("mon_err",   32'(bus16.error), 32'(exp_q[0].err));
                if (bus16.out_ready) void'(exp_q.pop_front());
            end
            if (bus16.in_valid && mon_ready) model(bus16.mode, bus16.encoder_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic [1:0] m, input logic [15:0] v);
        bus16.in_valid   = 1'b1;
        bus16.mode       = m;
        bus16.encoder_in = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        int          beats[4];
        logic [15:0] rv;

        tbl[0] = '{2'd0, 16'h0400, 10, 1'b0, 1'b0};
        tbl[1] = '{2'd0, 16'h0003,  0, 1'b0, 1'b1};
        tbl[2] = '{2'd0, 16'h0000,  0, 1'b1, 1'b1};
        tbl[3] = '{2'd1, 16'h8421,  0, 1'b0, 1'b0};
        tbl[4] = '{2'd2, 16'h8421, 15, 1'b0, 1'b0};
        tbl[5] = '{2'd1, 16'h0000,  0, 1'b1, 1'b0};
        tbl[6] = '{2'd2, 16'h0001,  0, 1'b0, 1'b0};
        tbl[7] = '{2'd3, 16'h0040,  6, 1'b0, 1'b0};
        tbl[8] = '{2'd3, 16'h0000,  0, 1'b1, 1'b0};
        tbl[9] = '{2'd0, 16'h8000, 15, 1'b0, 1'b0};
        beats = '{0, 5, 10, 15};

        reset = 1'b1; enable = 1'b1;
        bus16.in_valid = 1'b0; bus16.mode = 2'd0; bus16.encoder_in = '0; bus16.out_ready = 1'b1;
        bus5.in_valid  = 1'b0; bus5.mode  = 2'd0; bus5.encoder_in  = '0; bus5.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus16.out_valid), 0);
        check("rst_idx",   32'(bus16.binary_out), 0);
        check("rst_last",  32'(bus16.out_last), 0);
        check("rst_zero",  32'(bus16.zero), 0);
        check("rst_err",   32'(bus16.error), 0);
        check("rst5_valid", 32'(bus5.out_valid), 0);
        step(); reset = 1'b0;

        // Single-beat vectors
        for (int t = 0; t < 10; t++) begin
            step(); drive16(tbl[t].mode, tbl[t].vec);
            @(negedge clk);
            check("tbl_in_ready", 32'(bus16.in_ready), 1);
            step(); bus16.in_valid = 1'b0;
            @(negedge clk);
            check("tbl_valid", 32'(bus16.out_valid), 1);
            check("tbl_idx",   32'(bus16.binary_out), 32'(tbl[t].idx));
            check("tbl_last",  32'(bus16.out_last), 1);
            check("tbl_zero",  32'(bus16.zero), 32'(tbl[t].zero));
            check("tbl_err",   32'(bus16.error), 32'(tbl[t].err));
            step();
            @(negedge clk);
            check("tbl_after_valid", 32'(bus16.out_valid), 0);
        end

        // Serialise with out_ready high
        step(); drive16(2'd3, 16'h8421);
        step(); bus16.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("scan_idx",  32'(bus16.binary_out), 32'(beats[k]));
            check("scan_last", 32'(bus16.out_last), (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        @(negedge clk);
        check("scan_done_valid", 32'(bus16.out_valid), 0);

        // Serialise with backpressure on beat 5
        step(); drive16(2'd3, 16'h8421);
        step(); bus16.in_valid = 1'b0;
        @(negedge clk);
        check("bp_idx0", 32'(bus16.binary_out), 0);
        step(); bus16.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_idx",  32'(bus16.binary_out), 5);
            check("bp_hold_last", 32'(bus16.out_last), 0);
            step();
        end
        bus16.out_ready = 1'b1;
        @(negedge clk); check("bp_idx5", 32'(bus16.binary_out), 5);
        step(); @(negedge clk); check("bp_idx10", 32'(bus16.binary_out), 10);
        step(); @(negedge clk); check("bp_idx15", 32'(bus16.binary_out), 15);
        check("bp_last15", 32'(bus16.out_last), 1);
        step(); @(negedge clk); check("bp_done_valid", 32'(bus16.out_valid), 0);

        // Back-to-back accept on the last-beat handshake
        step(); drive16(2'd3, 16'h0006);
        step(); bus16.in_valid = 1'b0;
        @(negedge clk); check("b2b_idx1", 32'(bus16.binary_out), 1);
        step(); drive16(2'd1, 16'h0010);
        @(negedge clk);
        check("b2b_idx2",  32'(bus16.binary_out), 2);
        check("b2b_last",  32'(bus16.out_last), 1);
        check("b2b_ready", 32'(bus16.in_ready), 1);
        step(); bus16.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_next_valid", 32'(bus16.out_valid), 1);
        check("b2b_next_idx",   32'(bus16.binary_out), 4);
        step();

        // Reset in the middle of a scan
        step(); drive16(2'd3, 16'h8421);
        step(); bus16.in_valid = 1'b0;
        step(); bus16.out_ready = 1'b0;
        @(negedge clk); check("rmid_idx5", 32'(bus16.binary_out), 5);
        step(); reset = 1'b1;
        step(); reset = 1'b0; bus16.out_ready = 1'b1;
        @(negedge clk); check("rmid_valid", 32'(bus16.out_valid), 0);
        step(); drive16(2'd1, 16'h0010);
        step(); bus16.in_valid = 1'b0;
        @(negedge clk);
        check("rmid_new_valid", 32'(bus16.out_valid), 1);
        check("rmid_new_idx",   32'(bus16.binary_out), 4);
        step();

        // enable low blocks accepts
        step(); enable = 1'b0; drive16(2'd1, 16'h0001);
        @(negedge clk); check("en_in_ready", 32'(bus16.in_ready), 0);
        step(); @(negedge clk); check("en_valid_a", 32'(bus16.out_valid), 0);
        step(); @(negedge clk); check("en_valid_b", 32'(bus16.out_valid), 0);
        step(); bus16.in_valid = 1'b0; enable = 1'b1;

        // enable falling mid-scan lets the scan finish
        step(); drive16(2'd3, 16'h00F0);
        step(); bus16.in_valid = 1'b0; enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("enscan_idx", 32'(bus16.binary_out), 32'(4 + k));
            step();
        end
        @(negedge clk); check("enscan_done", 32'(bus16.out_valid), 0);
        step(); enable = 1'b1;

        // Five-bit instance
        step(); bus5.in_valid = 1'b1; bus5.mode = 2'd2; bus5.encoder_in = 5'b10000;
        step(); bus5.in_valid = 1'b0;
        @(negedge clk);
        check("w5_valid", 32'(bus5.out_valid), 1);
        check("w5_msb",   32'(bus5.binary_out), 4);
        check("w5_last",  32'(bus5.out_last), 1);
        step(); bus5.in_valid = 1'b1; bus5.mode = 2'd3; bus5.encoder_in = 5'b10001;
        step(); bus5.in_valid = 1'b0;
        @(negedge clk);
        check("w5_scan0", 32'(bus5.binary_out), 0);
        check("w5_last0", 32'(bus5.out_last), 0);
        step(); @(negedge clk);
        check("w5_scan4", 32'(bus5.binary_out), 4);
        check("w5_last4", 32'(bus5.out_last), 1);
        step(); @(negedge clk);
        check("w5_done", 32'(bus5.out_valid), 0);

        // Random traffic, scored by the monitor
        for (int c = 0; c < 600; c++) begin
            step();
            case ($urandom_range(3))
                0:       rv = 16'h0000;
                1:       rv = 16'h0001 << $urandom_range(15);
                2:       rv = 16'($urandom);
                default: rv = 16'($urandom) & 16'($urandom);
            endcase
            bus16.in_valid   = ($urandom_range(1) == 1);
            bus16.mode       = 2'($urandom_range(3));
            bus16.encoder_in = rv;
            bus16.out_ready  = ($urandom_range(3) != 0);
            enable           = ($urandom_range(7) != 0);
            reset            = ($urandom_range(149) == 0);
        end

        step(); bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; enable = 1'b1; reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        step(); @(negedge clk);
        check("drain_idle", 32'(bus16.out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Parametrised, registered successor to the team's 16-to-4 one-hot encoder.
- Converts a WIDTH-bit request vector to a binary index and supports four run-time modes:
  - strict one-hot with error flag;
  - LSB priority;
  - MSB priority;
  - serialise, which emits the index of every set bit over successive beats.
- Sits between request-collection logic and a downstream consumer.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, input vector width; must be >= 2.
- OUT_W, $clog2(WIDTH), index width; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new input is accepted; an in-flight output still completes.
- mode  input  2  0 = strict one-hot, 1 = LSB priority, 2 = MSB priority, 3 = serialise LSB-first.
- in_valid  input  1  encoder_in and mode are valid.
- in_ready  output  1  block can accept a new input this cycle.
- encoder_in  input  WIDTH  request vector.
- out_valid  output  1  binary_out and the flags are valid.
- out_ready  input  1  downstream accepts the current beat.
- binary_out  output  OUT_W  encoded index.
- out_last  output  1  final beat for the accepted input.
- zero  output  1  accepted vector was all zeros.
- error  output  1  mode 0 only: vector was not exactly one-hot.

Behaviour:
- Reset, sampled at a clk edge, clears all outputs and state:
  - out_valid=0, binary_out=0, out_last=0, zero=0, error=0;
  - internal mask=0, state=IDLE.
- Reset overrides every other input, including mid-serialisation. The pending mask is discarded and out_valid=0 from the next cycle.
- Accept condition: in_valid && in_ready.
  - in_ready = enable && (!out_valid || (out_ready && out_last)).
  - This allows back-to-back accepts with no bubble.
- Latency: first output beat appears one cycle after the accept edge (registered outputs, out_valid=1).
- mode and encoder_in are latched at accept. Later changes have no effect on the in-flight job.
- States:
  - IDLE: out_valid=0.
  - HOLD: single-beat result pending.
  - SCAN: mode 3, multiple beats pending.
- IDLE -> HOLD on accept in modes 0/1/2, or in mode 3 when the vector has at most one set bit.
- IDLE -> SCAN on accept in mode 3 with two or more set bits.
- HOLD -> IDLE on out_ready with no new accept. HOLD/SCAN -> HOLD/SCAN directly when a new accept coincides with the last-beat handshake.
- Mode 0:
  - exactly one bit k set: binary_out=k, error=0;
  - otherwise binary_out=0, error=1;
  - zero=1 additionally when the vector is all zeros.
- Mode 1: binary_out = index of lowest set bit.
- Mode 2: binary_out = index of highest set bit.
- Modes 1/2: error=0 always.
- Mode 3:
  - latch mask = encoder_in.
  - Each beat: binary_out = lowest set bit of mask; out_last=1 iff exactly one bit remains.
  - On each handshake (out_valid && out_ready), clear that bit and present the next lowest on the following cycle.
  - Beat count equals popcount.
- Single-beat results (modes 0/1/2, mode 3 popcount <= 1): out_last=1.
- All-zero input in any mode: exactly one beat with binary_out=0, zero=1, out_last=1. error=1 in mode 0 only.
- Backpressure: while out_valid && !out_ready, binary_out, out_last, zero and error hold stable and the mask is unchanged.
- enable falling mid-SCAN: the scan continues to completion; only new accepts are blocked.
- Width rules:
  - indices are zero-extended to OUT_W;
  - non-power-of-two WIDTH is legal, and binary_out never exceeds WIDTH-1.

Test Plan:
- Mode 0, in_valid=1 with encoder_in=16'h0400 -> next cycle out_valid=1, binary_out=10, error=0, zero=0, out_last=1.
- Mode 0: 16'h0003 -> binary_out=0, error=1. Then 16'h0000 -> binary_out=0, error=1, zero=1.
- Mode 1 with 16'h8421 -> binary_out=0. Mode 2 with the same vector -> binary_out=15. Both error=0.
- Mode 3 with 16'h8421 and out_ready held high -> four consecutive beats 0,5,10,15, out_last only on 15.
  - Rerun with out_ready low for 3 cycles at beat 5 -> 5 held stable, then 10 and 15 follow.
- Back-to-back:
  - a second input presented during the last-beat handshake is accepted that same cycle (in_ready=1) and its result follows with no idle cycle.
  - reset asserted mid-scan after beat 5 -> out_valid=0 next cycle; a subsequent mode-1 input 16'h0010 yields 4.
- WIDTH=5 instance (OUT_W=3), mode 2 with 5'b10000 -> 4. enable=0 with in_valid=1 -> in_ready=0, no output.
